// File: rtl/sprite_layer_arbiter.sv
// Sprite layer arbiter: shadowed sprite registers, fixed-priority hit test, shared ROM fetch.
// Optional sprite 0/1 collision flag built when COLLISION_DETECT_EN is defined.
module sprite_layer_arbiter #(
  parameter int N_SPR  = 4,
  parameter int SPR_W  = 11,
  parameter int SPR_H  = 22,
  parameter int ADDR_W = 10
) (
  input  logic                       vga_clk,
  input  logic                       Reset,
  input  logic [9:0]                 DrawX,
  input  logic [9:0]                 DrawY,
  input  logic                       frame_start,
  input  logic [N_SPR*10-1:0]        spr_x,
  input  logic [N_SPR*10-1:0]        spr_y,
  input  logic [N_SPR-1:0]           spr_en,
  input  logic [N_SPR*ADDR_W-1:0]    spr_base,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [3:0]                 rom_q,
  output logic [3:0]                 pix_idx,
  output logic                       pix_valid,
  output logic [$clog2(N_SPR)-1:0]   pix_owner,
  output logic                       collision
);

  localparam int OW = $clog2(N_SPR);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                  state_q, state_d;
  logic [N_SPR*10-1:0]     sx_q, sx_d;
  logic [N_SPR*10-1:0]     sy_q, sy_d;
  logic [N_SPR-1:0]        sen_q, sen_d;
  logic [N_SPR*ADDR_W-1:0] sb_q, sb_d;

  logic [N_SPR-1:0]        hit;
  logic                    any_hit;
  logic [OW-1:0]           win;
  logic [9:0]              wx, wy, dx, dy;
  logic [ADDR_W-1:0]       wb, addr_calc;
  logic                    active;

  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic                    v1_q, v1_d, v2_q, v2_d;
  logic [OW-1:0]           o1_q, o1_d, o2_q, o2_d;
  logic                    pv_q, pv_d;
  logic [3:0]              idx_q, idx_d;
  logic [OW-1:0]           own_q, own_d;

  assign active = (state_q == ACTIVE);

  // Bounds compared at 11 bits so a sprite near column 1023 never wraps.
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_SPR; i++) begin
      hit[i] = sen_q[i]
        && ({1'b0, DrawX} >= 11'(sx_q[10*i +: 10]))
        && ({1'b0, DrawX} <  11'(sx_q[10*i +: 10]) + 11'(SPR_W))
        && ({1'b0, DrawY} >= 11'(sy_q[10*i +: 10]))
        && ({1'b0, DrawY} <  11'(sy_q[10*i +: 10]) + 11'(SPR_H));
    end
  end

  always_comb begin
    win     = '0;
    any_hit = 1'b0;
    for (int i = N_SPR - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win     = OW'(i);
        any_hit = 1'b1;
      end
    end
  end

  always_comb begin
    wx = sx_q[10*win +: 10];
    wy = sy_q[10*win +: 10];
    wb = sb_q[ADDR_W*win +: ADDR_W];
    dx = DrawX - wx;
    dy = DrawY - wy;
    addr_calc = wb + ADDR_W'(32'(dy) * SPR_W) + ADDR_W'(dx);
  end

  always_comb begin
    state_d = state_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    sen_d   = sen_q;
    sb_d    = sb_q;
    if (frame_start) begin
      state_d = ACTIVE;
      sx_d    = spr_x;
      sy_d    = spr_y;
      sen_d   = spr_en;
      sb_d    = spr_base;
    end
    addr_d = any_hit ? addr_calc : addr_q;
    v1_d   = any_hit && active;
    o1_d   = win;
    v2_d   = v1_q;
    o2_d   = o1_q;
    // Palette index 0 is transparent; lower-priority sprites are not retried.
    pv_d   = v2_q && (rom_q != 4'd0);
    idx_d  = pv_d ? rom_q : 4'd0;
    own_d  = pv_d ? o2_q : '0;
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state_q <= IDLE;
      sx_q    <= '0;
      sy_q    <= '0;
      sen_q   <= '0;
      sb_q    <= '0;
      addr_q  <= '0;
      v1_q    <= 1'b0;
      o1_q    <= '0;
      v2_q    <= 1'b0;
      o2_q    <= '0;
      pv_q    <= 1'b0;
      idx_q   <= '0;
      own_q   <= '0;
    end else begin
      state_q <= state_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      sen_q   <= sen_d;
      sb_q    <= sb_d;
      addr_q  <= addr_d;
      v1_q    <= v1_d;
      o1_q    <= o1_d;
      v2_q    <= v2_d;
      o2_q    <= o2_d;
      pv_q    <= pv_d;
      idx_q   <= idx_d;
      own_q   <= own_d;
    end
  end

  assign rom_addr  = addr_q;
  assign pix_valid = pv_q;
  assign pix_idx   = idx_q;
  assign pix_owner = own_q;

`ifdef COLLISION_DETECT_EN
  logic both;
  logic acc_q, acc_d;
  logic coll_q, coll_d;

  assign both = hit[0] && hit[1] && active;

  // An overlap in the frame_start cycle belongs to the new frame.
  always_comb begin
    acc_d  = acc_q | both;
    coll_d = coll_q;
    if (frame_start) begin
      coll_d = acc_q;
      acc_d  = both;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      acc_q  <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      coll_q <= coll_d;
    end
  end

  assign collision = coll_q;
`else
  assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_layer_arbiter.sv
// Directed bench for sprite_layer_arbiter with a behavioural ROM and a
// latency-tagged scoreboard for the pixel outputs.
module tb_sprite_layer_arbiter;

  logic        vga_clk = 1'b0;
  logic        Reset;
  logic [9:0]  DrawX, DrawY;
  logic        frame_start;
  logic [39:0] spr_x, spr_y;
  logic [3:0]  spr_en;
  logic [39:0] spr_base;
  logic [9:0]  rom_addr;
  logic [3:0]  rom_q;
  logic [3:0]  pix_idx;
  logic        pix_valid;
  logic [1:0]  pix_owner;
  logic        collision;

`ifdef COLLISION_DETECT_EN
  localparam logic CEXP = 1'b1;
`else
  localparam logic CEXP = 1'b0;
`endif

  sprite_layer_arbiter dut (
    .vga_clk     (vga_clk),
    .Reset       (Reset),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .frame_start (frame_start),
    .spr_x       (spr_x),
    .spr_y       (spr_y),
    .spr_en      (spr_en),
    .spr_base    (spr_base),
    .rom_addr    (rom_addr),
    .rom_q       (rom_q),
    .pix_idx     (pix_idx),
    .pix_valid   (pix_valid),
    .pix_owner   (pix_owner),
    .collision   (collision)
  );

  always #5 vga_clk = ~vga_clk;

  logic [3:0] mem [1024];
  always @(posedge vga_clk) rom_q <= mem[rom_addr];

  int cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         due;
    logic       v;
    logic [3:0] idx;
    logic [1:0] own;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  always @(negedge vga_clk) begin
    while (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      checks++;
      assert ({pix_valid, pix_idx, pix_owner} === {e.v, e.idx, e.own})
      else begin
        errors++;
        $error("FAIL pix@%0d obs v=%0b idx=%0d own=%0d exp v=%0b idx=%0d own=%0d",
               cyc, pix_valid, pix_idx, pix_owner, e.v, e.idx, e.own);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr"}, 32'(rom_addr), 0);
    chk({tag, "_valid"}, 32'(pix_valid), 0);
    chk({tag, "_idx"}, 32'(pix_idx), 0);
    chk({tag, "_owner"}, 32'(pix_owner), 0);
    chk({tag, "_coll"}, 32'(collision), 0);
  endtask

  task automatic px(input int x, input int y, input logic v, input int idx,
                    input int own, input int a = -1);
    exp_t t;
    DrawX = 10'(x);
    DrawY = 10'(y);
    t.due = cyc + 3;
    t.v   = v;
    t.idx = 4'(idx);
    t.own = 2'(own);
    sb.push_back(t);
    @(negedge vga_clk);
    if (a >= 0) chk("rom_addr", 32'(rom_addr), 32'(a));
  endtask

  task automatic idle(input int n);
    DrawX = 10'd600;
    DrawY = 10'd600;
    repeat (n) @(negedge vga_clk);
  endtask

  task automatic frame();
    frame_start = 1'b1;
    @(negedge vga_clk);
    frame_start = 1'b0;
  endtask

  task automatic setspr(input int i, input int x, input int y, input int b, input logic en);
    spr_x[10*i +: 10]    = 10'(x);
    spr_y[10*i +: 10]    = 10'(y);
    spr_base[10*i +: 10] = 10'(b);
    spr_en[i]            = en;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 4'd0;
    for (int i = 2; i <= 20; i++) if (i != 6) mem[i] = 4'(i) | 4'd1;
    mem[1]   = 4'd7;
    mem[3]   = 4'hB;
    mem[27]  = 4'd5;
    mem[231] = 4'd9;
    mem[300] = 4'd3;
    mem[301] = 4'd9;
    mem[307] = 4'd4;

    Reset = 1'b1;
    frame_start = 1'b0;
    DrawX = 10'd600;
    DrawY = 10'd600;
    spr_x = '0;
    spr_y = '0;
    spr_en = '0;
    spr_base = '0;
    repeat (3) @(negedge vga_clk);
    chk_zero("reset");
    Reset = 1'b0;

    setspr(0, 100, 50, 0, 1'b1);
    px(105, 52, 1'b0, 0, 0);
    idle(4);
    frame();
    px(105, 52, 1'b1, 5, 0, 27);
    px(99, 52, 1'b0, 0, 0);
    px(111, 52, 1'b0, 0, 0);
    px(110, 52, 1'b0, 0, 0, 32);
    px(100, 71, 1'b1, 9, 0, 231);
    px(100, 72, 1'b0, 0, 0);
    idle(4);

    setspr(0, 200, 100, 0, 1'b1);
    setspr(2, 205, 100, 300, 1'b1);
    frame();
    px(201, 100, 1'b1, 7, 0, 1);
    px(206, 100, 1'b0, 0, 0, 6);
    px(212, 100, 1'b1, 4, 2, 307);
    px(200, 100, 1'b0, 0, 0, 0);
    idle(4);

    setspr(0, 400, 100, 0, 1'b1);
    px(201, 100, 1'b1, 7, 0);
    frame_start = 1'b1;
    px(201, 100, 1'b1, 7, 0);
    frame_start = 1'b0;
    px(201, 100, 1'b0, 0, 0);
    px(401, 100, 1'b1, 7, 0, 1);
    idle(4);

    setspr(0, 1020, 50, 0, 1'b1);
    setspr(2, 0, 0, 0, 1'b0);
    frame();
    for (int x = 0; x <= 10; x++) px(x, 50, 1'b0, 0, 0);
    chk("rom_addr_hold", 32'(rom_addr), 1);
    px(1023, 50, 1'b1, 11, 0, 3);
    idle(4);

    setspr(0, 300, 300, 0, 1'b1);
    setspr(1, 305, 300, 100, 1'b1);
    frame();
    chk("coll_before", 32'(collision), 0);
    px(306, 300, 1'b0, 0, 0);
    idle(3);
    frame();
    chk("coll_set", 32'(collision), 32'(CEXP));
    idle(3);
    frame();
    chk("coll_clear", 32'(collision), 0);
    idle(4);

    DrawX = 10'd301;
    DrawY = 10'd300;
    repeat (4) @(negedge vga_clk);
    chk("pre_rst_valid", 32'(pix_valid), 1);
    chk("pre_rst_idx", 32'(pix_idx), 7);
    Reset = 1'b1;
    @(negedge vga_clk);
    Reset = 1'b0;
    chk_zero("midrst");
    repeat (5) @(negedge vga_clk);
    chk("post_rst_valid", 32'(pix_valid), 0);
    frame();
    repeat (3) @(negedge vga_clk);
    chk("refrm_valid", 32'(pix_valid), 1);
    chk("refrm_idx", 32'(pix_idx), 7);

    idle(6);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_layer_arbiter.md
SPRITE_LAYER_ARBITER -- requirements
Module: sprite_layer_arbiter

Interface
REQ-001 Parameter N_SPR, default 4: number of sprites sharing one sprite ROM (power of 2, at least 2).
REQ-002 Parameter SPR_W, default 11: sprite width in pixels.
REQ-003 Parameter SPR_H, default 22: sprite height in pixels.
REQ-004 Parameter ADDR_W, default 10: sprite ROM address width.
REQ-005 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-006 Port vga_clk, input, 1: sole clock.
REQ-007 Port Reset, input, 1: synchronous active-high reset.
REQ-008 Port DrawX, input, 10: current pixel column.
REQ-009 Port DrawY, input, 10: current pixel row.
REQ-010 Port frame_start, input, 1: one-cycle pulse, once per frame, during vertical blanking.
REQ-011 Port spr_x, input, N_SPR*10: live sprite left edges; sprite i occupies bits [10i+9:10i].
REQ-012 Port spr_y, input, N_SPR*10: live sprite top edges; same packing as spr_x.
REQ-013 Port spr_en, input, N_SPR: live sprite enables.
REQ-014 Port spr_base, input, N_SPR*ADDR_W: live ROM base address of each sprite image.
REQ-015 Port rom_addr, output, ADDR_W: address to the shared synchronous-read ROM.
REQ-016 Port rom_q, input, 4: ROM palette index, valid one cycle after rom_addr.
REQ-017 Port pix_idx, output, 4: palette index for the winning sprite.
REQ-018 Port pix_valid, output, 1: sprite pixel present and opaque.
REQ-019 Port pix_owner, output, log2(N_SPR): index of the winning sprite.
REQ-020 Port collision, output, 1: sprite 0 / sprite 1 overlap flag for the previous frame.

Function
REQ-021 Shadow registers: in the cycle after frame_start is high, shadow registers capture spr_x, spr_y, spr_en and spr_base; all hit tests use only shadow values.
REQ-022 FSM state IDLE: entered on reset; pix_valid is held 0.
REQ-023 FSM transition IDLE->ACTIVE: on the first frame_start; ACTIVE persists until Reset.
REQ-024 Hit test for sprite i: shadow_en[i] and x <= DrawX < x+SPR_W and y <= DrawY < y+SPR_H, evaluated at 11-bit width; no wrap-around at 1023.
REQ-025 Arbitration: fixed priority, lowest hitting index wins; exactly one ROM access per pixel.
REQ-026 Address: rom_addr = base + (DrawY-y)*SPR_W + (DrawX-x) for the winner, truncated modulo 2^ADDR_W; registered, valid in cycle n+1 for DrawX/DrawY sampled in cycle n.
REQ-027 No hit: rom_addr holds its previous value.
REQ-028 Output stage: pix_idx, pix_owner and pix_valid are registered, valid in cycle n+3 (3-clock latency).
REQ-029 pix_valid = 1 only when ACTIVE, a hit occurred and rom_q != 0; index 0 is transparent.
REQ-030 Transparent winning pixel: pix_valid = 0; lower-priority sprites are not consulted.
REQ-031 Output values when pix_valid = 0: pix_idx = 0 and pix_owner = 0.
REQ-032 frame_start coinciding with a hit: the hit completes using the old shadow values.

Reset
REQ-033 Reset: rom_addr, pix_idx, pix_valid, pix_owner and collision go to 0; all shadow registers go to 0; the pipeline is flushed; the FSM enters IDLE.
REQ-034 Reset mid-frame: outputs are 0 in the cycle after Reset is sampled high; pix_valid stays 0 until the next frame_start.

Configuration
REQ-035 Macro COLLISION_DETECT_EN, defined: a sticky accumulator sets whenever sprites 0 and 1 both pass the hit test on the same pixel in ACTIVE. On frame_start, collision <= accumulator and the accumulator clears; a hit in the frame_start cycle counts toward the new frame.
REQ-036 Macro COLLISION_DETECT_EN, undefined: the collision port remains and is tied to 0; no accumulator logic is built.

Verification
REQ-037 Reset, then frame_start with sprite 0 at (100,50), base 0, enabled; drive DrawX=105, DrawY=52 -> rom_addr=27 one cycle later; rom_q=5 -> pix_valid=1, pix_idx=5, pix_owner=0 three cycles after the pixel.
REQ-038 Sprites 0 and 2 both cover (200,100); sprite 2 base 300 -> owner 0 wins; with sprite 0 rom_q=0 -> pix_valid=0, sprite 2 not shown.
REQ-039 Live spr_x changed mid-frame without frame_start -> hits still use the old position; after frame_start, the new position applies.
REQ-040 Sprite at x=1020, DrawX=0..10 -> no hit (no wrap); DrawX=1023 -> hit, address offset 3.
REQ-041 COLLISION_DETECT_EN defined: sprites 0 and 1 overlap at one pixel in frame k -> collision=1 after frame k+1 start, 0 after frame k+2 start if no overlap; undefined: collision stays 0.
REQ-042 Reset asserted mid-line with pix_valid=1 -> all outputs 0 the next cycle; pix_valid stays 0 until frame_start.
